// File: rtl/fb_pkg.sv
// Shared constants for the ping-pong frame buffer: geometry, word widths and
// writer FSM encodings.
package fb_pkg;
  localparam int MEM_DEPTH  = 130560;
  localparam int ADDR_WIDTH = 17;
  localparam int DATA_WIDTH = 16;
  localparam int DROP_W     = 8;

  localparam logic [1:0] W_SYNC    = 2'd0;
  localparam logic [1:0] W_WRITE   = 2'd1;
  localparam logic [1:0] W_BLOCKED = 2'd2;
endpackage

// File: rtl/fb_bank_tracker.sv
// Bank ownership for the ping-pong buffer: writer FSM, full flags, reader bank
// and the saturating dropped-frame counter.
module fb_bank_tracker
  import fb_pkg::*;
#(
  parameter int MEM_DEPTH  = fb_pkg::MEM_DEPTH,
  parameter int ADDR_WIDTH = fb_pkg::ADDR_WIDTH,
  parameter int DROP_W     = fb_pkg::DROP_W
) (
  input  logic                  iClk,
  input  logic                  iRst_n,
  input  logic                  wev,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic                  rd_release,
  output logic                  wr_accept,
  output logic                  wr_bank,
  output logic                  rd_bank,
  output logic                  rd_frame_ready,
  output logic                  frame_done,
  output logic [DROP_W-1:0]     drop_cnt
);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_DEPTH - 1);

  logic [1:0]        state, state_nxt;
  logic [1:0]        bank_full, full_nxt;
  logic              wr_bank_nxt, rd_bank_nxt;
  logic [DROP_W-1:0] drop_nxt;
  logic              addr_zero, release_ok;

  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign addr_zero      = (wr_addr == '0);
  assign release_ok     = rd_release & bank_full[rd_bank];
  assign wr_accept      = wev & ((state == W_WRITE) | ((state == W_SYNC) & addr_zero));
  assign frame_done     = wr_accept & (wr_addr == LAST_ADDR);
  assign rd_frame_ready = bank_full[rd_bank];

  // Release is folded into full_nxt first so a coinciding last write sees the freed bank.
  always_comb begin
    state_nxt   = state;
    full_nxt    = bank_full;
    wr_bank_nxt = wr_bank;
    rd_bank_nxt = rd_bank;
    drop_nxt    = drop_cnt;
    if (release_ok) begin
      full_nxt[rd_bank] = 1'b0;
      rd_bank_nxt       = ~rd_bank;
    end
    case (state)
      W_SYNC, W_WRITE: begin
        if (frame_done) begin
          full_nxt[wr_bank] = 1'b1;
          if (!full_nxt[~wr_bank]) begin
            wr_bank_nxt = ~wr_bank;
            state_nxt   = W_WRITE;
          end else begin
            state_nxt   = W_BLOCKED;
          end
        end else if (wr_accept) begin
          state_nxt = W_WRITE;
        end
      end
      W_BLOCKED: begin
        if (wev && addr_zero) drop_nxt = sat_inc(drop_cnt);
        if (release_ok && (rd_bank != wr_bank)) begin
          wr_bank_nxt = ~wr_bank;
          state_nxt   = W_SYNC;
        end
      end
      default: state_nxt = W_SYNC;
    endcase
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state     <= W_SYNC;
      bank_full <= 2'b00;
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      state     <= state_nxt;
      bank_full <= full_nxt;
      wr_bank   <= wr_bank_nxt;
      rd_bank   <= rd_bank_nxt;
      drop_cnt  <= drop_nxt;
    end
  end
endmodule

// File: rtl/frame_buf_arbiter.sv
// Ping-pong frame-buffer controller: write-priority arbitration of one
// single-port RAM between the pixel writer and the frame reader.
module frame_buf_arbiter
  import fb_pkg::*;
#(
  parameter int MEM_DEPTH  = fb_pkg::MEM_DEPTH,
  parameter int ADDR_WIDTH = fb_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = fb_pkg::DATA_WIDTH,
  parameter int DROP_W     = fb_pkg::DROP_W
) (
  input  logic                  iClk,
  input  logic                  iRst_n,
  input  logic                  i_Clk_en,
  input  logic                  i_wr_valid,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic                  i_rd_req,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr,
  input  logic                  i_rd_release,
  output logic                  o_rd_frame_ready,
  output logic                  o_rd_grant,
  output logic                  o_rd_valid,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  output logic                  o_rd_err,
  output logic                  o_frame_done,
  output logic [DROP_W-1:0]     o_drop_cnt,
  output logic                  o_mem_en,
  output logic                  o_mem_we,
  output logic [ADDR_WIDTH:0]   o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata
);
  localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(MEM_DEPTH);

  logic wev, wr_accept, wr_bank, rd_bank, rd_in_range;
  logic rd_vld_p1;

  assign wev         = i_Clk_en & i_wr_valid;
  assign rd_in_range = (i_rd_addr < DEPTH_A);

  fb_bank_tracker #(
    .MEM_DEPTH (MEM_DEPTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .DROP_W    (DROP_W)
  ) u_tracker (
    .iClk          (iClk),
    .iRst_n        (iRst_n),
    .wev           (wev),
    .wr_addr       (i_wr_addr),
    .rd_release    (i_rd_release),
    .wr_accept     (wr_accept),
    .wr_bank       (wr_bank),
    .rd_bank       (rd_bank),
    .rd_frame_ready(o_rd_frame_ready),
    .frame_done    (o_frame_done),
    .drop_cnt      (o_drop_cnt)
  );

  // A write always wins; a denied read is simply re-presented by the reader.
  assign o_rd_err    = i_rd_req & ~rd_in_range;
  assign o_rd_grant  = i_rd_req & o_rd_frame_ready & rd_in_range & ~wr_accept;
  assign o_mem_en    = wr_accept | o_rd_grant;
  assign o_mem_we    = wr_accept;
  assign o_mem_wdata = wr_accept ? i_wr_data : '0;

  always_comb begin
    o_mem_addr = '0;
    if (wr_accept)       o_mem_addr = {wr_bank, i_wr_addr};
    else if (o_rd_grant) o_mem_addr = {rd_bank, i_rd_addr};
  end

  // p1: RAM data returns one cycle after the granted address
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) rd_vld_p1 <= 1'b0;
    else         rd_vld_p1 <= o_rd_grant;
  end

  assign o_rd_valid = rd_vld_p1;
  assign o_rd_data  = rd_vld_p1 ? i_mem_rdata : '0;
endmodule

// File: tb/tb_frame_buf_arbiter.sv
// Directed bench for frame_buf_arbiter using a 16-pixel frame and a small RAM model.
module tb_frame_buf_arbiter;
  localparam int D = 16;

  logic        iClk, iRst_n;
  logic        i_Clk_en, i_wr_valid, i_rd_req, i_rd_release;
  logic [16:0] i_wr_addr, i_rd_addr;
  logic [15:0] i_wr_data, i_mem_rdata, o_rd_data, o_mem_wdata;
  logic        o_rd_frame_ready, o_rd_grant, o_rd_valid, o_rd_err, o_frame_done;
  logic [7:0]  o_drop_cnt;
  logic        o_mem_en, o_mem_we;
  logic [17:0] o_mem_addr;

  frame_buf_arbiter #(.MEM_DEPTH(D)) dut (
    .iClk(iClk), .iRst_n(iRst_n), .i_Clk_en(i_Clk_en), .i_wr_valid(i_wr_valid),
    .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data), .i_rd_req(i_rd_req),
    .i_rd_addr(i_rd_addr), .i_rd_release(i_rd_release),
    .o_rd_frame_ready(o_rd_frame_ready), .o_rd_grant(o_rd_grant),
    .o_rd_valid(o_rd_valid), .o_rd_data(o_rd_data), .o_rd_err(o_rd_err),
    .o_frame_done(o_frame_done), .o_drop_cnt(o_drop_cnt), .o_mem_en(o_mem_en),
    .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
    .i_mem_rdata(i_mem_rdata)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  // Single-port RAM model with one-cycle registered read
  logic [15:0] ram [0:31];
  logic [4:0]  ram_idx;
  assign ram_idx = {o_mem_addr[17], o_mem_addr[3:0]};
  always @(posedge iClk) begin
    if (o_mem_en) begin
      if (o_mem_we) ram[ram_idx] <= o_mem_wdata;
      else          i_mem_rdata  <= ram[ram_idx];
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic cyc(input logic ce, input logic wv, input logic [16:0] wa,
                     input logic [15:0] wd, input logic rq, input logic [16:0] ra,
                     input logic rel);
    @(posedge iClk);
    #1;
    i_Clk_en = ce; i_wr_valid = wv; i_wr_addr = wa; i_wr_data = wd;
    i_rd_req = rq; i_rd_addr = ra; i_rd_release = rel;
    #3;
  endtask

  task automatic wr(input logic [16:0] a, input logic [15:0] d);
    cyc(1'b1, 1'b1, a, d, 1'b0, 17'd0, 1'b0);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 17'd0, 16'd0, 1'b0, 17'd0, 1'b0);
  endtask

  task automatic rd(input logic [16:0] a);
    cyc(1'b0, 1'b0, 17'd0, 16'd0, 1'b1, a, 1'b0);
  endtask

  task automatic chk_wr(input string nm, input logic bank, input logic [16:0] a,
                        input logic [15:0] d);
    chk({nm, "_en"},   {o_mem_en, o_mem_we}, 2'b11);
    chk({nm, "_addr"}, o_mem_addr, {bank, a});
    chk({nm, "_wd"},   o_mem_wdata, d);
  endtask

  typedef struct {
    logic        ce, wv;
    logic [16:0] wa;
    logic [15:0] wd;
    logic        rq;
    logic [16:0] ra;
    logic        rel;
    logic        en, we;
    logic [17:0] addr;
    logic        gnt, err, vld;
    logic [15:0] rdata;
  } vec_t;

  vec_t tbl [8];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    //            ce    wv    wa        wd        rq    ra           rel   en    we    addr        gnt   err   vld   rdata
    tbl[0] = '{1'b1, 1'b1, 17'd1, 16'h2001, 1'b1, 17'd3,      1'b0, 1'b1, 1'b1, 18'h20001, 1'b0, 1'b0, 1'b0, 16'h0};
    tbl[1] = '{1'b1, 1'b0, 17'd0, 16'h0,    1'b1, 17'd3,      1'b0, 1'b1, 1'b0, 18'h00003, 1'b1, 1'b0, 1'b0, 16'h0};
    tbl[2] = '{1'b0, 1'b0, 17'd0, 16'h0,    1'b0, 17'd0,      1'b0, 1'b0, 1'b0, 18'h0,     1'b0, 1'b0, 1'b1, 16'h1003};
    tbl[3] = '{1'b0, 1'b0, 17'd0, 16'h0,    1'b1, 17'd16,     1'b0, 1'b0, 1'b0, 18'h0,     1'b0, 1'b1, 1'b0, 16'h0};
    tbl[4] = '{1'b0, 1'b0, 17'd0, 16'h0,    1'b1, 17'd130560, 1'b0, 1'b0, 1'b0, 18'h0,     1'b0, 1'b1, 1'b0, 16'h0};
    tbl[5] = '{1'b1, 1'b1, 17'd2, 16'h2002, 1'b1, 17'd5,      1'b0, 1'b1, 1'b1, 18'h20002, 1'b0, 1'b0, 1'b0, 16'h0};
    tbl[6] = '{1'b0, 1'b1, 17'd3, 16'h2003, 1'b1, 17'd5,      1'b0, 1'b1, 1'b0, 18'h00005, 1'b1, 1'b0, 1'b0, 16'h0};
    tbl[7] = '{1'b0, 1'b0, 17'd0, 16'h0,    1'b0, 17'd0,      1'b0, 1'b0, 1'b0, 18'h0,     1'b0, 1'b0, 1'b1, 16'h1005};

    i_Clk_en = 0; i_wr_valid = 0; i_wr_addr = 0; i_wr_data = 0;
    i_rd_req = 0; i_rd_addr = 0; i_rd_release = 0; iRst_n = 0;
    repeat (3) @(posedge iClk);
    #4;
    chk("rst_en",    o_mem_en, 1'b0);
    chk("rst_we",    o_mem_we, 1'b0);
    chk("rst_gnt",   o_rd_grant, 1'b0);
    chk("rst_err",   o_rd_err, 1'b0);
    chk("rst_vld",   o_rd_valid, 1'b0);
    chk("rst_rdata", o_rd_data, 16'h0);
    chk("rst_ready", o_rd_frame_ready, 1'b0);
    chk("rst_fdone", o_frame_done, 1'b0);
    chk("rst_drop",  o_drop_cnt, 8'h0);
    @(posedge iClk);
    #1 iRst_n = 1;

    // Reset then fill bank 0
    for (int a = 0; a < D; a++) begin
      wr(17'(a), 16'h1000 + 16'(a));
      chk_wr("fill0", 1'b0, 17'(a), 16'h1000 + 16'(a));
      chk("fill0_fdone", o_frame_done, a == D - 1);
      if (a == D - 1) chk("fill0_ready_late", o_rd_frame_ready, 1'b0);
    end
    idle();
    chk("fill0_ready", o_rd_frame_ready, 1'b1);
    chk("fill0_fdone_off", o_frame_done, 1'b0);
    wr(17'd0, 16'h2000);
    chk_wr("bank1_first", 1'b1, 17'd0, 16'h2000);

    // Collision, out-of-range and clock-enable vectors
    for (int i = 0; i < 8; i++) begin
      cyc(tbl[i].ce, tbl[i].wv, tbl[i].wa, tbl[i].wd, tbl[i].rq, tbl[i].ra, tbl[i].rel);
      chk($sformatf("vec%0d_en", i),  {o_mem_en, o_mem_we}, {tbl[i].en, tbl[i].we});
      if (tbl[i].en) chk($sformatf("vec%0d_addr", i), o_mem_addr, tbl[i].addr);
      chk($sformatf("vec%0d_gnt", i), o_rd_grant, tbl[i].gnt);
      chk($sformatf("vec%0d_err", i), o_rd_err, tbl[i].err);
      chk($sformatf("vec%0d_vld", i), o_rd_valid, tbl[i].vld);
      if (tbl[i].vld) chk($sformatf("vec%0d_rdata", i), o_rd_data, tbl[i].rdata);
    end

    // Slow reader: finish bank 1 without release, writer blocks
    for (int a = 3; a < D; a++) begin
      wr(17'(a), 16'h2000 + 16'(a));
      chk_wr("fill1", 1'b1, 17'(a), 16'h2000 + 16'(a));
    end
    chk("fill1_fdone", o_frame_done, 1'b1);
    idle();
    chk("blk_ready", o_rd_frame_ready, 1'b1);
    wr(17'd0, 16'h3000);
    chk("blk_wr0_en", o_mem_en, 1'b0);
    wr(17'd1, 16'h3001);
    chk("blk_wr1_en", o_mem_en, 1'b0);
    chk("blk_drop1", o_drop_cnt, 8'd1);
    rd(17'd4);
    chk("blk_rd_gnt", o_rd_grant, 1'b1);
    chk("blk_rd_addr", o_mem_addr, 18'h00004);
    idle();
    chk("blk_rd_data", o_rd_data, 16'h1004);
    for (int n = 0; n < 300; n++) wr(17'd0, 16'h3000);
    idle();
    chk("drop_sat", o_drop_cnt, 8'hff);
    cyc(1'b0, 1'b0, 17'd0, 16'd0, 1'b0, 17'd0, 1'b1);
    idle();
    chk("rel_ready", o_rd_frame_ready, 1'b1);
    chk("rel_drop", o_drop_cnt, 8'hff);
    rd(17'd2);
    chk("rel_rd_addr", o_mem_addr, 18'h20002);
    idle();
    chk("rel_rd_data", o_rd_data, 16'h2002);
    wr(17'd7, 16'h4007);
    chk("sync_skip_en", o_mem_en, 1'b0);
    wr(17'd0, 16'h4000);
    chk_wr("sync_resume", 1'b0, 17'd0, 16'h4000);

    // Reset mid-frame
    for (int a = 1; a <= 5; a++) wr(17'(a), 16'h4000 + 16'(a));
    #1 iRst_n = 0;
    #1;
    chk("mrst_ready", o_rd_frame_ready, 1'b0);
    chk("mrst_drop",  o_drop_cnt, 8'h0);
    chk("mrst_vld",   o_rd_valid, 1'b0);
    chk("mrst_en",    o_mem_en, 1'b0);
    chk("mrst_fdone", o_frame_done, 1'b0);
    idle();
    @(posedge iClk);
    #1 iRst_n = 1;
    cyc(1'b0, 1'b0, 17'd0, 16'd0, 1'b0, 17'd0, 1'b1);
    for (int a = 6; a <= 8; a++) begin
      wr(17'(a), 16'h5000 + 16'(a));
      chk("mrst_discard_en", o_mem_en, 1'b0);
    end
    for (int a = 0; a < D; a++) begin
      wr(17'(a), 16'h5000 + 16'(a));
      chk("mrst_fill_bank", o_mem_addr, {1'b0, 17'(a)});
    end
    chk("mrst_fdone_last", o_frame_done, 1'b1);
    idle();
    chk("mrst_fill_ready", o_rd_frame_ready, 1'b1);

    // Release coincides with last write of bank 1 while bank 0 is full
    for (int a = 0; a < D - 1; a++) begin
      wr(17'(a), 16'h6000 + 16'(a));
      chk("co_bank1", o_mem_addr[17], 1'b1);
    end
    cyc(1'b1, 1'b1, 17'(D - 1), 16'h600f, 1'b0, 17'd0, 1'b1);
    chk_wr("co_last", 1'b1, 17'(D - 1), 16'h600f);
    chk("co_fdone", o_frame_done, 1'b1);
    idle();
    chk("co_ready", o_rd_frame_ready, 1'b1);
    chk("co_drop",  o_drop_cnt, 8'h0);
    wr(17'd0, 16'h7000);
    chk_wr("co_next_bank0", 1'b0, 17'd0, 16'h7000);
    rd(17'(D - 1));
    chk("co_rd_addr", o_mem_addr, 18'h2000f);
    idle();
    chk("co_rd_data", o_rd_data, 16'h600f);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/frame_buf_arbiter.md
# frame_buf_arbiter

Ping-pong frame-buffer controller between the RGB565 pixel writer and the CNN pixel reader. The block shares one single-port frame RAM of 2×MEM_DEPTH words (two banks) and arbitrates accesses cycle by cycle, with writes taking priority. It sequences bank ownership at frame granularity so the reader always sees a complete frame. When the reader falls behind, whole frames are dropped and counted.

## Interface
- MEM_DEPTH, 130560: pixels per frame (words per bank).
- ADDR_WIDTH, 17: pixel address width; RAM address is ADDR_WIDTH+1.
- DATA_WIDTH, 16: RGB565 word width.
- DROP_W, 8: width of dropped-frame counter.

Ports:
- iClk  in  1  clock; one clock domain.
- iRst_n  in  1  asynchronous, active-low reset.
- i_Clk_en  in  1  pixel-rate enable; qualifies the write side only.
- i_wr_valid  in  1  pixel valid from the writer.
- i_wr_addr  in  ADDR_WIDTH  pixel address, 0..MEM_DEPTH-1, incrementing, restarts at 0 each frame.
- i_wr_data  in  DATA_WIDTH  RGB565 pixel.
- i_rd_req  in  1  read request.
- i_rd_addr  in  ADDR_WIDTH  read pixel address.
- i_rd_release  in  1  one-cycle pulse: reader is done with the current bank.
- o_rd_frame_ready  out  1  the reader's bank holds a complete frame.
- o_rd_grant  out  1  read accepted this cycle (combinational).
- o_rd_valid  out  1  read data valid.
- o_rd_data  out  DATA_WIDTH  read data.
- o_rd_err  out  1  pulse: request with i_rd_addr ≥ MEM_DEPTH.
- o_frame_done  out  1  pulse: last pixel of a frame written.
- o_drop_cnt  out  DROP_W  dropped frames, saturating.
- o_mem_en, o_mem_we  out  1  RAM enable and write enable.
- o_mem_addr  out  ADDR_WIDTH+1  RAM address, {bank, pixel_addr}.
- o_mem_wdata  out  DATA_WIDTH  RAM write data.
- i_mem_rdata  in  DATA_WIDTH  RAM read data, registered one cycle after address.

## Operation
- **State:** wr_bank, rd_bank, bank_full[1:0], writer FSM {W_SYNC, W_WRITE, W_BLOCKED}.
- **Reset values:** wr_bank=0, rd_bank=0, bank_full=0, FSM=W_SYNC, o_drop_cnt=0. All outputs are 0.
- **Write event (wev):** i_Clk_en & i_wr_valid.
- **W_SYNC:** a wev with i_wr_addr==0 writes that pixel and goes to W_WRITE. Other pixels are discarded.
- **W_WRITE:** every wev writes {wr_bank, i_wr_addr}. When a wev has i_wr_addr==MEM_DEPTH-1:
  - set bank_full[wr_bank] and pulse o_frame_done;
  - if bank_full[~wr_bank]==0, toggle wr_bank and stay in W_WRITE;
  - otherwise go to W_BLOCKED.
- **W_BLOCKED:** all wevs are discarded. Each wev with i_wr_addr==0 increments o_drop_cnt, saturating at all-ones. On release of the other bank, toggle wr_bank and go to W_SYNC.
- **Reader:**
  - o_rd_frame_ready = bank_full[rd_bank].
  - i_rd_release while ready clears bank_full[rd_bank] and toggles rd_bank.
  - i_rd_release while not ready is ignored.
- **Arbitration per cycle:**
  - An accepted write (W_WRITE, or W_SYNC with addr 0) owns the RAM: o_mem_en=1, o_mem_we=1.
  - Otherwise, i_rd_req & frame_ready & i_rd_addr<MEM_DEPTH is granted: o_mem_en=1, o_mem_we=0, addr {rd_bank, i_rd_addr}.
  - A denied read must be held by the reader until it is granted.
  - An out-of-range request pulses o_rd_err and is never granted.
- **Simultaneous release and last write:** the release is applied first, so the writer toggles into the freed bank and stays in W_WRITE (no block, no drop).
- **Reset mid-frame:** all bank contents are invalid and the block restarts in W_SYNC.

## Timing
- o_rd_grant and all o_mem_* outputs are combinational from same-cycle inputs and state.
- o_rd_valid is asserted exactly one cycle after o_rd_grant. o_rd_data = i_mem_rdata in that cycle. Read latency is 1.
- o_frame_done is asserted in the cycle of the last write.
- bank_full, wr_bank and FSM state update on the next edge.
- o_rd_frame_ready rises the cycle after the last write of that bank.

## Structure
- Shared package `fb_pkg`: MEM_DEPTH, ADDR_WIDTH, DATA_WIDTH, writer FSM state encodings (W_SYNC=2'd0, W_WRITE=2'd1, W_BLOCKED=2'd2).
- Natural sub-module: `fb_bank_tracker`, which owns wr_bank, rd_bank, bank_full, the writer FSM and the drop counter. The top level keeps the arbitration mux and the read-valid pipeline.

## Test plan
- **Reset then fill:** stream MEM_DEPTH pixels with addr 0..MEM_DEPTH-1 -> o_frame_done at the last pixel; next cycle o_rd_frame_ready=1 and wr_bank=1; second-frame writes land at o_mem_addr bit17=1.
- **Collision:** wev and i_rd_req in the same cycle -> write performed, o_rd_grant=0; next cycle read granted; o_rd_valid one cycle later with the data written earlier to {0, addr}.
- **Slow reader:** two frames written with no release -> W_BLOCKED; third frame -> o_drop_cnt=1. Release -> rd_bank=1 with ready=1; writer enters W_SYNC on bank 0 and resumes at the next addr 0.
- **Release coincides with last write of bank 1 (bank 0 full):** -> no W_BLOCKED, wr_bank=0, o_drop_cnt unchanged.
- **Address and release errors:** i_rd_addr=130560 with i_rd_req -> o_rd_err=1, o_rd_grant=0. i_rd_release while not ready -> no state change.
- **Reset mid-frame at pixel 5000:** -> outputs 0, bank_full=0; pixels 5001.. are discarded until addr 0 arrives.
